fft_reorder_stream: RTL

Parametrised, runtime-configurable output reorder stage for the pipelined FFT cores. It accepts one bit-reversed complex sample per `i_ce` from the last butterfly stage and stores whole frames in a ping-pong buffer. Frames leave in natural order, or fftshifted (DC centred), over a valid/ready stream with frame markers. It replaces the fixed-size, handshake-free bit-reversal stage and supports any power-of-two size from 8 to 2^LGMAX.

---
 rtl/fft_reorder_stream.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_reorder_stream.sv
// Output reorder stage for the pipelined FFT: bit-reversed input frames are
// stored in a ping-pong buffer and streamed out in natural or fftshifted order.
module fft_reorder_stream #(
    parameter int IWIDTH = 21,
    parameter int LGMAX  = 8,
    parameter int LGMIN  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [3:0]            i_cfg_lgsize,
    input  logic                  i_cfg_shift,
    input  logic                  i_ce,
    input  logic                  i_sync,
    input  logic [2*IWIDTH-1:0]   i_data,
    output logic [2*IWIDTH-1:0]   o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sync,
    output logic                  o_last,
    output logic                  o_drop,
    output logic                  o_resync,
    output logic [15:0]           o_frame_cnt
);
    localparam int DW   = 2 * IWIDTH;
    localparam int AW   = LGMAX + 1;
    localparam int IDXW = (LGMAX > 1) ? $clog2(LGMAX) : 1;

    typedef enum logic [1:0] {W_IDLE = 2'b00, W_FILL = 2'b01, W_SKIP = 2'b10} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [3:0] clamp_lg(input logic [3:0] lg);
        logic [3:0] r;
        if (lg < 4'(LGMIN))      r = 4'(LGMIN);
        else if (lg > 4'(LGMAX)) r = 4'(LGMAX);
        else                     r = lg;
        return r;
    endfunction

    function automatic logic [LGMAX-1:0] last_idx(input logic [3:0] lg);
        return {LGMAX{1'b1}} >> (4'(LGMAX) - lg);
    endfunction

    function automatic logic [LGMAX-1:0] half_idx(input logic [3:0] lg);
        return {{(LGMAX-1){1'b0}}, 1'b1} << (lg - 4'd1);
    endfunction

    // Reverse only the low lg bits of k; upper bits stay zero.
    function automatic logic [LGMAX-1:0] bitrev(input logic [LGMAX-1:0] k, input logic [3:0] lg);
        logic [LGMAX-1:0] r;
        logic [IDXW-1:0]  src;
        r = '0;
        for (int i = 0; i < LGMAX; i++) begin
            src = IDXW'(int'(lg) - 1 - i);
            if (i < int'(lg)) r[i] = k[src];
            else              r[i] = 1'b0;
        end
        return r;
    endfunction

    logic [DW-1:0]      r_mem [0:(1<<AW)-1];

    wstate_t            r_wstate;
    logic               r_wbank;
    logic [LGMAX-1:0]   r_k;
    logic [1:0]         r_full;
    logic [1:0][3:0]    r_lg;
    logic [1:0]         r_sh;
    logic               r_drop;
    logic               r_resync;

    rstate_t            r_rstate;
    logic               r_rbank;
    logic [LGMAX-1:0]   r_j;
    logic [DW-1:0]      r_p_data;
    logic               r_p_valid, r_p_sync, r_p_last;

    logic [DW-1:0]      r_o_data, r_s_data;
    logic               r_o_valid, r_o_sync, r_o_last;
    logic               r_s_valid, r_s_sync, r_s_last;
    logic               r_relbank;
    logic [15:0]        r_frame_cnt;

    logic               w_pop, w_release, w_sync_in, w_bank_free, w_we, w_room, w_issue;
    logic [3:0]         w_lg_in, w_wlg, w_rlg;
    logic [LGMAX-1:0]   w_wlast, w_rlast, w_jcur;
    logic [AW-1:0]      w_waddr, w_raddr;
    logic [1:0]         w_occ;

    // Write-side decode: a sync in any writer state claims the target bank if it is free.
    always_comb begin
        w_pop       = r_o_valid & i_ready;
        w_release   = w_pop & r_o_last;
        w_sync_in   = i_ce & i_sync;
        w_lg_in     = clamp_lg(i_cfg_lgsize);
        w_wlg       = r_lg[r_wbank];
        w_wlast     = last_idx(w_wlg);
        w_bank_free = ~r_full[r_wbank] | (w_release & (r_relbank == r_wbank));
        w_we        = 1'b0;
        w_waddr     = '0;
        if (w_sync_in) begin
            w_we    = w_bank_free;
            w_waddr = {r_wbank, {LGMAX{1'b0}}};
        end else if (i_ce && (r_wstate == W_FILL)) begin
            w_we    = 1'b1;
            w_waddr = {r_wbank, bitrev(r_k, w_wlg)};
        end else begin
            w_we    = 1'b0;
        end
    end

    // Read-side decode: issue only while output register, skid and read stage hold fewer than two.
    always_comb begin
        w_rlg   = r_lg[r_rbank];
        w_rlast = last_idx(w_rlg);
        w_occ   = {1'b0, r_o_valid} + {1'b0, r_s_valid} + {1'b0, r_p_valid};
        w_room  = (w_occ - {1'b0, w_pop}) < 2'd2;
        w_jcur  = (r_rstate == R_DRAIN) ? r_j : {LGMAX{1'b0}};
        w_issue = w_room & ((r_rstate == R_DRAIN) | r_full[r_rbank]);
        w_raddr = {r_rbank, w_jcur ^ (r_sh[r_rbank] ? half_idx(w_rlg) : {LGMAX{1'b0}})};
    end

    // Frame buffer storage with a one-cycle registered read.
    always_ff @(posedge i_clk) begin
        if (w_we)    r_mem[w_waddr] <= i_data;
        if (w_issue) r_p_data       <= r_mem[w_raddr];
    end

    // Writer FSM plus bank bookkeeping (full flags are also cleared by the reader release).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wstate <= W_IDLE;
            r_wbank  <= 1'b0;
            r_k      <= '0;
            r_full   <= 2'b00;
            r_lg     <= '0;
            r_sh     <= 2'b00;
            r_drop   <= 1'b0;
            r_resync <= 1'b0;
        end else begin
            r_drop   <= 1'b0;
            r_resync <= 1'b0;
            if (w_release) r_full[r_relbank] <= 1'b0;
            case (r_wstate)
                W_IDLE, W_SKIP: begin
                    if (w_sync_in) begin
                        if (w_bank_free) begin
                            r_lg[r_wbank] <= w_lg_in;
                            r_sh[r_wbank] <= i_cfg_shift;
                            r_k           <= LGMAX'(1);
                            r_wstate      <= W_FILL;
                        end else begin
                            r_drop   <= 1'b1;
                            r_wstate <= W_SKIP;
                        end
                    end
                end
                W_FILL: begin
                    if (w_sync_in) begin
                        r_resync <= 1'b1;
                        if (w_bank_free) begin
                            r_lg[r_wbank] <= w_lg_in;
                            r_sh[r_wbank] <= i_cfg_shift;
                            r_k           <= LGMAX'(1);
                        end else begin
                            r_drop   <= 1'b1;
                            r_k      <= '0;
                            r_wstate <= W_SKIP;
                        end
                    end else if (i_ce) begin
                        if (r_k == w_wlast) begin
                            r_full[r_wbank] <= 1'b1;
                            r_wbank         <= ~r_wbank;
                            r_k             <= '0;
                            r_wstate        <= W_IDLE;
                        end else begin
                            r_k <= r_k + LGMAX'(1);
                        end
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                    r_k      <= '0;
                end
            endcase
        end
    end

    // Reader FSM: walks the full bank and tags each read with its frame markers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rstate  <= R_IDLE;
            r_rbank   <= 1'b0;
            r_j       <= '0;
            r_p_valid <= 1'b0;
            r_p_sync  <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= w_issue;
            if (w_issue) begin
                r_p_sync <= (w_jcur == {LGMAX{1'b0}});
                r_p_last <= (w_jcur == w_rlast);
            end
            case (r_rstate)
                R_IDLE: begin
                    if (r_full[r_rbank]) begin
                        r_j      <= w_issue ? LGMAX'(1) : {LGMAX{1'b0}};
                        r_rstate <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (w_issue) begin
                        if (w_jcur == w_rlast) begin
                            r_rbank  <= ~r_rbank;
                            r_j      <= '0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_j <= r_j + LGMAX'(1);
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                    r_j      <= '0;
                end
            endcase
        end
    end

    // Output register with skid; the bank is released when its last sample is accepted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_o_data    <= '0;
            r_o_valid   <= 1'b0;
            r_o_sync    <= 1'b0;
            r_o_last    <= 1'b0;
            r_s_data    <= '0;
            r_s_valid   <= 1'b0;
            r_s_sync    <= 1'b0;
            r_s_last    <= 1'b0;
            r_relbank   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            if (!r_o_valid || w_pop) begin
                if (r_s_valid) begin
                    r_o_data  <= r_s_data;
                    r_o_sync  <= r_s_sync;
                    r_o_last  <= r_s_last;
                    r_s_valid <= r_p_valid;
                    r_s_data  <= r_p_data;
                    r_s_sync  <= r_p_sync;
                    r_s_last  <= r_p_last;
                end else begin
                    r_o_valid <= r_p_valid;
                    if (r_p_valid) begin
                        r_o_data <= r_p_data;
                        r_o_sync <= r_p_sync;
                        r_o_last <= r_p_last;
                    end
                end
            end else if (r_p_valid) begin
                r_s_valid <= 1'b1;
                r_s_data  <= r_p_data;
                r_s_sync  <= r_p_sync;
                r_s_last  <= r_p_last;
            end
            if (w_release) begin
                r_relbank   <= ~r_relbank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_data      = r_o_data;
    assign o_valid     = r_o_valid;
    assign o_sync      = r_o_sync;
    assign o_last      = r_o_last;
    assign o_drop      = r_drop;
    assign o_resync    = r_resync;
    assign o_frame_cnt = r_frame_cnt;

endmodule
